// File: rtl/bp_mem_cmd_arbiter.sv
// bp_mem_cmd_arbiter: round-robin wormhole arbiter merging requester flit links onto one registered DRAM command link
module bp_mem_cmd_arbiter #(
    parameter int num_req_p    = 4,
    parameter int flit_width_p = 64,
    parameter int len_width_p  = 4,
    parameter int len_offset_p = 0,
    localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic [num_req_p-1:0]                v_i,
    input  logic [num_req_p*flit_width_p-1:0]   data_i,
    output logic [num_req_p-1:0]                ready_o,
    output logic                                v_o,
    output logic [flit_width_p-1:0]             data_o,
    input  logic                                ready_i,
    output logic [id_width_lp-1:0]              grant_id_o
);
    typedef enum logic {IDLE, SEND} state_e;
    state_e                   state_r, state_n;
    logic                     out_v_r, slot_free, found, acc;
    logic [flit_width_p-1:0]  out_data_r, flit;
    logic [id_width_lp-1:0]   ptr_r, grant_r, sel, src;
    logic [len_width_p-1:0]   rem_r, len;
    // ready is gated by reset so nothing handshakes while the block is held in reset
    assign slot_free  = reset_n_i & (~out_v_r | ready_i);
    assign v_o        = out_v_r;
    assign data_o     = out_data_r;
    assign grant_id_o = grant_r;
    always_comb begin
        int idx;
        idx   = 0;
        sel   = ptr_r;
        found = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = (int'(ptr_r) + i) % num_req_p;
            if (!found && v_i[idx]) begin
                found = 1'b1;
                sel   = id_width_lp'(idx);
            end
        end
    end
    always_comb begin
        ready_o = '0;
        src     = (state_r == SEND) ? grant_r : sel;
        if (state_r == IDLE) ready_o[sel] = slot_free & found;
        else ready_o[grant_r] = slot_free;
        acc     = v_i[src] & ready_o[src];
        flit    = data_i[int'(src)*flit_width_p +: flit_width_p];
        len     = flit[len_offset_p +: len_width_p];
        state_n = state_r;
        if (acc) state_n = (state_r == IDLE) ? ((len != '0) ? SEND : IDLE)
                                             : ((rem_r == len_width_p'(1)) ? IDLE : SEND);
    end
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= IDLE;
            out_v_r    <= 1'b0;
            out_data_r <= '0;
            ptr_r      <= '0;
            grant_r    <= '0;
            rem_r      <= '0;
        end else begin
            state_r <= state_n;
            if (acc) begin
                out_v_r    <= 1'b1;
                out_data_r <= flit;
            end else if (ready_i) out_v_r <= 1'b0;
            if (acc && state_r == IDLE) begin
                grant_r <= sel;
                ptr_r   <= (sel == id_width_lp'(num_req_p - 1)) ? '0 : sel + 1'b1;
                rem_r   <= len;
            end else if (acc) rem_r <= rem_r - 1'b1;
        end
    end
endmodule

// File: tb/tb_bp_mem_cmd_arbiter.sv
// tb_bp_mem_cmd_arbiter: scenario tasks with per-requester source queues and an in-order output scoreboard
module tb_bp_mem_cmd_arbiter;
    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   v_i;
    logic [255:0] data_i;
    logic [3:0]   ready_o;
    logic         v_o;
    logic [63:0]  data_o;
    logic         ready_i;
    logic [1:0]   grant_id_o;

    logic [63:0]  src_q[4][$];
    logic [63:0]  exp_q[$];
    logic [3:0]   en;
    logic [3:0]   hs;
    int           errors = 0;
    int           checks = 0;

    bp_mem_cmd_arbiter dut (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
        .v_o(v_o), .data_o(data_o), .ready_i(ready_i), .grant_id_o(grant_id_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] flit(int r, int p, int i, int len);
        return {8'(r), 16'(p), 8'(i), 28'h0, 4'(len)};
    endfunction

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            v_i[k] = en[k] && (src_q[k].size() > 0);
            data_i[k*64 +: 64] = (src_q[k].size() > 0) ? src_q[k][0] : 64'h0;
        end
    endtask

    task automatic send(int r, int p, int len);
        for (int i = 0; i <= len; i++) src_q[r].push_back(flit(r, p, i, (i == 0) ? len : 0));
    endtask

    task automatic expect_pkt(int r, int p, int len);
        for (int i = 0; i <= len; i++) exp_q.push_back(flit(r, p, i, (i == 0) ? len : 0));
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // handshakes are sampled mid-cycle, when inputs and ready_o are settled for the coming edge
    always @(negedge clk) begin
        logic [63:0] e;
        if (reset_n) begin
            hs = v_i & ready_o;
            if (v_o && ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL flit_out: got %h, expected no flit", data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (data_o !== e) begin
                        errors++;
                        $display("FAIL flit_out: got %h, expected %h", data_o, e);
                    end
                end
            end
        end else hs = '0;
    end

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 4; k++) if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        hs = '0;
        drive();
    end

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            cyc();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d flits still outstanding, expected 0", exp_q.size());
        end
        cyc();
        checks++;
        if (v_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_drain: v_o=%b expected 0", v_o);
        end
    endtask

    task automatic test_reset();
        repeat (3) cyc();
        checks++;
        if (v_o !== 1'b0 || data_o !== 64'h0 || ready_o !== 4'h0 || grant_id_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: v_o=%b data_o=%h ready_o=%b grant=%0d expected 0/0/0/0",
                     v_o, data_o, ready_o, grant_id_o);
        end
    endtask

    task automatic test_single();
        reset_n = 1'b1;
        send(0, 1, 2);
        expect_pkt(0, 1, 2);
        drive();
        #1;
        checks++;
        if (ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL first_cycle_accept: ready_o=%b expected 0001", ready_o);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (v_o !== 1'b1 || data_o !== flit(0, 1, i, (i == 0) ? 2 : 0)) begin
                errors++;
                $display("FAIL single_flit%0d: v_o=%b data_o=%h expected 1/%h", i, v_o, data_o,
                         flit(0, 1, i, (i == 0) ? 2 : 0));
            end
        end
        cyc();
        checks++;
        if (v_o !== 1'b0 || ready_o !== 4'h0) begin
            errors++;
            $display("FAIL single_idle: v_o=%b ready_o=%b expected 0/0000", v_o, ready_o);
        end
        drain();
    endtask

    task automatic test_round_robin();
        int ord[4] = '{1, 2, 3, 0};
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 4; i++) begin
                send(ord[i], 20 + j*4 + ord[i], 0);
                expect_pkt(ord[i], 20 + j*4 + ord[i], 0);
            end
        drive();
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++;
            if (v_o !== 1'b1 || grant_id_o !== 2'(ord[i%4])) begin
                errors++;
                $display("FAIL rr_grant%0d: v_o=%b grant=%0d expected 1/%0d", i, v_o, grant_id_o, ord[i%4]);
            end
        end
        drain();
    endtask

    task automatic test_lock();
        send(1, 40, 3);
        send(0, 41, 0);
        send(2, 42, 0);
        expect_pkt(1, 40, 3);
        expect_pkt(2, 42, 0);
        expect_pkt(0, 41, 0);
        drive();
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ready_o !== 4'b0010) begin
                errors++;
                $display("FAIL lock_ready%0d: ready_o=%b expected 0010", i, ready_o);
            end
            cyc();
        end
        checks++;
        if (ready_o !== 4'b0100) begin
            errors++;
            $display("FAIL lock_next: ready_o=%b expected 0100", ready_o);
        end
        cyc();
        checks++;
        if (grant_id_o !== 2'd2) begin
            errors++;
            $display("FAIL lock_grant: grant=%0d expected 2", grant_id_o);
        end
        drain();
    endtask

    task automatic test_backpressure();
        send(3, 50, 4);
        expect_pkt(3, 50, 4);
        drive();
        cyc();
        cyc();
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (v_o !== 1'b1 || ready_o !== 4'h0 || data_o !== flit(3, 50, 1, 0)) begin
                errors++;
                $display("FAIL stall%0d: v_o=%b ready_o=%b data_o=%h expected 1/0000/%h",
                         i, v_o, ready_o, data_o, flit(3, 50, 1, 0));
            end
        end
        ready_i = 1'b1;
        drain();
    endtask

    task automatic test_bubble();
        send(2, 60, 3);
        send(3, 61, 0);
        expect_pkt(2, 60, 3);
        expect_pkt(3, 61, 0);
        drive();
        cyc();
        en[2] = 1'b0;
        drive();
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (v_o !== 1'b0 || ready_o !== 4'b0100 || grant_id_o !== 2'd2) begin
                errors++;
                $display("FAIL bubble%0d: v_o=%b ready_o=%b grant=%0d expected 0/0100/2",
                         i, v_o, ready_o, grant_id_o);
            end
        end
        en[2] = 1'b1;
        drive();
        drain();
    endtask

    task automatic test_reset_mid_packet();
        send(1, 70, 5);
        expect_pkt(1, 70, 5);
        drive();
        cyc();
        cyc();
        checks++;
        if (v_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_packet_valid: v_o=%b expected 1", v_o);
        end
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (v_o !== 1'b0 || ready_o !== 4'h0 || grant_id_o !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: v_o=%b ready_o=%b grant=%0d expected 0/0000/0",
                     v_o, ready_o, grant_id_o);
        end
        for (int k = 0; k < 4; k++) src_q[k].delete();
        exp_q.delete();
        drive();
        cyc();
        cyc();
        reset_n = 1'b1;
        send(3, 80, 0);
        send(1, 81, 0);
        send(0, 82, 0);
        expect_pkt(0, 82, 0);
        expect_pkt(1, 81, 0);
        expect_pkt(3, 80, 0);
        drive();
        #1;
        checks++;
        if (ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_ready: ready_o=%b expected 0001", ready_o);
        end
        cyc();
        checks++;
        if (grant_id_o !== 2'd0) begin
            errors++;
            $display("FAIL post_reset_grant: grant=%0d expected 0", grant_id_o);
        end
        drain();
    endtask

    initial begin
        reset_n = 1'b0;
        ready_i = 1'b1;
        en      = 4'hF;
        v_i     = '0;
        data_i  = '0;
        hs      = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_backpressure();
        test_bubble();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bp_mem_cmd_arbiter.md
BP_MEM_CMD_ARBITER -- requirements
Module: bp_mem_cmd_arbiter

Interface
REQ-001 Parameter num_req_p, default 4: number of requester links (one per core-complex column) sharing the single DRAM command link.
REQ-002 Parameter flit_width_p, default 64: flit width, equal to mem_noc_flit_width_p.
REQ-003 Parameter len_width_p, default 4: width of the packet-length field carried in each header flit.
REQ-004 Parameter len_offset_p, default 0: LSB position of the length field within the header flit.
REQ-005 Port clk_i, input, 1: sole clock; all state updates on its rising edge.
REQ-006 Port reset_n_i, input, 1: asynchronous, active-low reset; asserting it clears all state immediately, and deassertion is synchronous to clk_i.
REQ-007 Port v_i, input, num_req_p: per-requester flit valid.
REQ-008 Port data_i, input, num_req_p x flit_width_p: per-requester flit payload.
REQ-009 Port ready_o, output, num_req_p: per-requester ready; a flit transfers when v_i[k] and ready_o[k] are both high.
REQ-010 Port v_o, input... (corrected) Port v_o, output, 1: DRAM-side flit valid.
REQ-011 Port data_o, output, flit_width_p: DRAM-side flit payload.
REQ-012 Port ready_i, input, 1: DRAM-side ready; a flit transfers when v_o and ready_i are both high.
REQ-013 Port grant_id_o, output, clog2(num_req_p): index of the requester that currently owns, or last owned, the link.

Function
REQ-014 The block shall contain a one-entry output register (out_v_r, out_data_r), with v_o = out_v_r and data_o = out_data_r.
- The slot is free in a cycle when out_v_r is 0 or ready_i is 1.
REQ-015 The FSM shall have two states:
- IDLE: no packet is in progress.
- SEND: a multi-flit packet is in progress for requester grant_r.
REQ-016 In IDLE, when the slot is free and any v_i is high, the block shall select one requester by round-robin.
- Search starts at index ptr_r and proceeds upward modulo num_req_p.
- Only the selected requester's ready_o shall be asserted; all other ready_o bits are 0.
REQ-017 In IDLE with no v_i high, or with the slot not free, all ready_o bits shall be 0.
REQ-018 On acceptance of a header flit from requester k, the block shall:
- load grant_r = k;
- load ptr_r = (k+1) mod num_req_p;
- load rem_r = the header length field (number of body flits following the header).
REQ-019 On a header acceptance, if the length field is 0 the FSM shall remain in IDLE; otherwise it shall go to SEND.
REQ-020 In SEND, ready_o[grant_r] shall equal slot-free, and all other ready_o bits shall be 0.
- Requests from other requesters shall be ignored until the packet completes (wormhole lock).
REQ-021 Each accepted body flit shall decrement rem_r by 1.
- Accepting a flit while rem_r = 1 shall return the FSM to IDLE.
REQ-022 Every accepted flit shall be written to the output register.
- The flit shall appear on data_o, with v_o = 1, exactly one cycle after acceptance.
- It shall stay stable until consumed by ready_i.
REQ-023 When the output register is consumed in a cycle with no new acceptance, out_v_r shall clear to 0.
- An accept and a drain in the same cycle shall keep out_v_r = 1 and replace the data, giving full throughput of one flit per cycle.
REQ-024 While v_o = 1 and ready_i = 0, out_data_r shall not change.
REQ-025 In SEND, a cycle where v_i[grant_r] is low shall cause no transfer and no state change; bubbles inside a packet are legal.
REQ-026 A requester deasserting v_i before transfer shall not cause any flit to be lost or duplicated.
REQ-027 grant_id_o shall equal grant_r at all times.
REQ-028 Packets from different requesters shall never interleave on data_o.

Reset
REQ-029 While reset_n_i = 0, the following shall hold:
- state = IDLE;
- out_v_r = 0, so v_o = 0;
- out_data_r = 0;
- ptr_r = 0, grant_r = 0, rem_r = 0;
- all ready_o = 0.
REQ-030 Reset asserted mid-packet shall abandon the packet immediately.
- After deassertion, the block shall arbitrate from ptr_r = 0 with the output register empty.
REQ-031 In the first cycle after reset deassertion, the block shall accept a header if a requester is valid and ready_i = 1.

Verification
REQ-032 Single requester: req0 sends a header with len = 2 plus 2 body flits (A, B, C), ready_i = 1 throughout.
- Expect v_o high for 3 consecutive cycles carrying A, B, C, each one cycle after its acceptance.
- Expect the FSM back in IDLE afterwards.
REQ-033 Round-robin: all 4 requesters continuously offer len = 0 packets, ready_i = 1.
- Expect grants in the order 0, 1, 2, 3, 0, 1, ...
- Expect one flit per cycle on data_o.
REQ-034 Lock: req1 starts a len = 3 packet while req0 and req2 are valid.
- Expect ready_o[0] = ready_o[2] = 0 until req1's 4th flit is accepted.
- Expect the next grant to go to req2.
REQ-035 Backpressure: hold ready_i = 0 for 5 cycles mid-packet.
- Expect data_o stable and all ready_o = 0 during the stall.
- Expect no flit lost or duplicated after ready_i returns to 1.
REQ-036 Bubble: the granted requester drops v_i for 2 cycles mid-packet.
- Expect no transfer and no state change during the bubble.
- Expect no other requester granted.
REQ-037 Reset mid-packet: pull reset_n_i low asynchronously (between clock edges) during SEND with v_o = 1.
- Expect v_o = 0 and all ready_o = 0 immediately.
- After release, expect the next grant to req0 when it is valid.
